fir_host_driver: RTL
====================

Name: fir_host_driver

Overview:
- Host-side initiator for the FIR filter's load/stream interface.
- Programs NUM_TAPS coefficients into the filter (coef_enable phase), then streams samples from an upstream valid/ready source (sample_enable phase).
- Captures filter results (out_enable/data_out) into a local result FIFO with valid/ready output.
- Sits between the system datapath and the fir instance; owns all of the filter's control inputs.

Parameters:
- NUM_TAPS, 5, number of coefficients loaded per programming pass
- DW, 8, sample/coefficient width (filter data_in width)
- OW, 16, filter result width (filter data_out width)
- RES_DEPTH, 4, result FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write coefficient table entry
- cfg_addr  in  clog2(NUM_TAPS)  coefficient index
- cfg_data  in  DW  coefficient value
- start  in  1  pulse: begin programming pass, then streaming
- stop  in  1  pulse: stop accepting samples, drain, return to IDLE
- s_valid  in  1  upstream sample valid
- s_data  in  DW  upstream sample
- s_ready  out  1  sample accepted when s_valid && s_ready
- fir_data_in  out  DW  to filter data_in
- fir_coef_enable  out  1  to filter coef_enable
- fir_sample_enable  out  1  to filter sample_enable
- fir_data_out  in  OW  from filter data_out
- fir_out_enable  in  1  from filter out_enable
- fir_error  in  1  from filter error
- r_valid  out  1  result FIFO not empty
- r_data  out  OW  result FIFO head
- r_ready  in  1  pop when r_valid && r_ready
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset values:
  - all outputs 0; fir_data_in = 0
  - state IDLE; FIFO empty; pending counter 0; err 0
  - coefficient table cleared to 0
- Coefficient table:
  - cfg_we writes table[cfg_addr] in any state except LOAD.
  - Writes during LOAD are ignored.
  - cfg_addr >= NUM_TAPS is ignored.
- States: IDLE, LOAD, SETTLE, STREAM, DRAIN, FAULT.
- IDLE:
  - start -> LOAD with tap index i = 0.
  - All fir enables 0, s_ready 0.
- LOAD:
  - Each cycle: fir_coef_enable = 1, fir_data_in = table[i] (registered outputs), i++.
  - After exactly NUM_TAPS cycles -> SETTLE. Tap 0 is presented first.
- SETTLE:
  - One cycle with fir_coef_enable = 0 and fir_sample_enable = 0 -> STREAM.
- STREAM:
  - s_ready = 1 iff (fifo_count + pending) < RES_DEPTH.
  - On accept: next cycle fir_sample_enable = 1, fir_data_in = s_data, pending++.
  - Without accept: fir_sample_enable = 0 and fir_data_in holds its value.
  - Throughput is one sample per cycle while space allows.
  - stop -> DRAIN; no sample is accepted in the stop cycle.
- DRAIN:
  - s_ready = 0; stay until pending == 0, then -> IDLE.
  - start is ignored in DRAIN.
- Result capture (LOAD through DRAIN):
  - fir_out_enable with pending > 0: push fir_data_out, pending--.
  - Push and accept in the same cycle: pending is unchanged.
  - fir_out_enable with pending == 0: spurious. Set err, drop the value, no state change.
  - Space reservation guarantees no FIFO overflow.
- FIFO: pop and push in the same cycle are both honoured; a full FIFO stays full.
- FAULT:
  - fir_error high in any non-IDLE state -> FAULT next cycle; err set.
  - In FAULT: all fir enables 0, s_ready 0, pending cleared.
  - FIFO contents remain readable.
  - Exit only via start (-> LOAD, err kept) or reset.
- start while busy (except FAULT) is ignored.
- err clears only on reset.
- Reset mid-operation returns everything to the reset values on the next edge. The coefficient table is also cleared, so it must be reprogrammed.

Test Plan:
- Load table {4,5,6,7,8}, pulse start -> fir_coef_enable high 5 consecutive cycles with fir_data_in 4,5,6,7,8; then 1 cycle both enables low; busy = 1 throughout.
- Stream samples 1,1,1 with r_ready = 1 and a model filter echoing after 2 cycles -> fir_sample_enable pulses 3 times, 3 results popped in order, pending returns to 0.
- r_ready = 0, RES_DEPTH = 4, continuous s_valid -> exactly 4 samples accepted, then s_ready = 0 until a pop; no result lost.
- stop with 2 samples in flight -> s_ready drops the same cycle; IDLE after 2nd fir_out_enable; start during DRAIN ignored.
- fir_error asserted mid-STREAM -> FAULT next cycle, enables 0, err = 1; start reloads coefficients, err remains 1.
- Reset asserted during LOAD at tap 2 -> next cycle all outputs 0, IDLE; fir_out_enable with pending = 0 afterwards sets err, FIFO stays empty.

Source files
------------

// File: rtl/fir_host_driver.sv
// Host-side initiator for the FIR filter: loads NUM_TAPS coefficients, then streams samples and captures results.
// Latency: coefficient/sample presented to the filter one cycle after acceptance; results readable one cycle after out_enable.
// Backpressure: s_ready only while result FIFO space (occupancy + samples in flight) remains; r_valid/r_ready pops results.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   cfg_we/addr/data       coefficient table write port (ignored while loading)
//   start, stop            begin a load+stream pass / stop streaming and drain
//   s_valid/s_ready/s_data upstream sample handshake
//   fir_*                  control and data towards/from the filter instance
//   r_valid/r_ready/r_data result FIFO head
//   busy, err              not idle / sticky error flag

module fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign rd_en = pop && (count != '0);
  assign wr_en = push && ((count != CW'(DEPTH)) || pop);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module fir_host_driver #(
  parameter int NUM_TAPS  = 5,
  parameter int DW        = 8,
  parameter int OW        = 16,
  parameter int RES_DEPTH = 4,
  localparam int AW       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int CW       = $clog2(RES_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  input  logic          stop,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [DW-1:0] fir_data_in,
  output logic          fir_coef_enable,
  output logic          fir_sample_enable,
  input  logic [OW-1:0] fir_data_out,
  input  logic          fir_out_enable,
  input  logic          fir_error,
  output logic          r_valid,
  output logic [OW-1:0] r_data,
  input  logic          r_ready,
  output logic          busy,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, DRAIN, FAULT} state_t;

  state_t        state, state_n;
  logic [AW-1:0] tap, tap_n;
  logic [CW-1:0] pending, pending_n;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [DW-1:0] tbl [NUM_TAPS];
  logic          coef_en_n, samp_en_n;
  logic [DW-1:0] data_n;
  logic          accept, push, pop, spurious, err_n;

  // Space is reserved for every sample in flight, so results can never overflow the FIFO.
  assign s_ready  = (state == STREAM) && !stop &&
                    ((int'(fifo_count) + int'(pending)) < RES_DEPTH);
  assign accept   = s_valid && s_ready;
  assign push     = fir_out_enable && (pending != '0);
  assign spurious = fir_out_enable && (pending == '0);
  assign r_valid  = !fifo_empty;
  assign pop      = r_valid && r_ready;
  assign busy     = (state != IDLE);
  assign err_n    = err || spurious || (fir_error && (state != IDLE));

  always_comb begin
    state_n   = state;
    tap_n     = tap;
    coef_en_n = 1'b0;
    samp_en_n = 1'b0;
    data_n    = fir_data_in;

    pending_n = pending;
    if (accept && !push)      pending_n = pending + CW'(1);
    else if (push && !accept) pending_n = pending - CW'(1);

    case (state)
      IDLE, FAULT: begin
        if (start) begin
          state_n   = LOAD;
          tap_n     = '0;
          coef_en_n = 1'b1;
          data_n    = tbl[0];
        end
      end
      LOAD: begin
        if (tap == AW'(NUM_TAPS - 1)) begin
          state_n = SETTLE;
        end else begin
          tap_n     = tap + AW'(1);
          coef_en_n = 1'b1;
          data_n    = tbl[tap_n];
        end
      end
      SETTLE: state_n = STREAM;
      STREAM: begin
        if (accept) begin
          samp_en_n = 1'b1;
          data_n    = s_data;
        end
        if (stop) state_n = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the last in-flight result is being captured.
        if (pending_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (fir_error && (state != IDLE)) state_n = FAULT;

    // Entering or sitting in FAULT abandons anything still in the filter.
    if (state_n == FAULT) begin
      coef_en_n = 1'b0;
      samp_en_n = 1'b0;
      pending_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tap               <= '0;
      pending           <= '0;
      err               <= 1'b0;
      fir_coef_enable   <= 1'b0;
      fir_sample_enable <= 1'b0;
      fir_data_in       <= '0;
      for (int k = 0; k < NUM_TAPS; k++) tbl[k] <= '0;
    end else begin
      state             <= state_n;
      tap               <= tap_n;
      pending           <= pending_n;
      err               <= err_n;
      fir_coef_enable   <= coef_en_n;
      fir_sample_enable <= samp_en_n;
      fir_data_in       <= data_n;
      if (cfg_we && (state != LOAD) && (int'(cfg_addr) < NUM_TAPS))
        tbl[cfg_addr] <= cfg_data;
    end
  end

  fifo #(.W(OW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (fir_data_out),
    .pop      (pop),
    .head     (r_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );
endmodule
